// File: rtl/bit_adder_seq_ctrl_if.sv
// Handshake bundle for the bit_adder sequencer: job start, tile fetch and result delivery.
interface bit_adder_seq_ctrl_if #(
  parameter int unsigned KW    = 5,
  parameter int unsigned SW    = 16,
  parameter int unsigned OUT_W = 16
);
  logic             start;
  logic [KW-1:0]    k_len;
  logic             busy;
  logic             tile_req;
  logic [KW-1:0]    tile_addr;
  logic             tile_ack;
  logic [SW-1:0]    ba_sum;
  logic [OUT_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             sat;

  modport master (
    input  start, k_len, tile_ack, ba_sum, out_ready,
    output busy, tile_req, tile_addr, acc_out, out_valid, sat
  );

  modport slave (
    output start, k_len, tile_ack, ba_sum, out_ready,
    input  busy, tile_req, tile_addr, acc_out, out_valid, sat
  );
endinterface

// File: rtl/bit_adder_seq_ctrl.sv
// Sequences K bit_adder tiles into one accumulated dot-product result.
// Optional SMAC_ACC_SAT_EN: clamp the result to OUT_W bits and flag sat; otherwise wrap.
module bit_adder_seq_ctrl #(
  parameter int unsigned M     = 16,
  parameter int unsigned Pa    = 8,
  parameter int unsigned Pw    = 4,
  parameter int unsigned KMAX  = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  bit_adder_seq_ctrl_if.master bus
);
  localparam int unsigned SW = Pa + Pw + $clog2(M);
  localparam int unsigned KW = $clog2(KMAX + 1);
  localparam int unsigned AW = SW + $clog2(KMAX);
  localparam logic [AW-1:0] OUT_MAX = AW'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    tile_addr_q, tile_addr_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic             sum_vld_q, sum_vld_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0] acc_out_q, acc_out_d;
  logic             sat_q, sat_d;
  logic             tile_req_q, tile_req_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    acc_sum;
  logic [KW-1:0]    k_clamp;
  logic [OUT_W-1:0] res_val;
  logic             res_sat;

  // Stage 2 adds whatever stage 1 captured last cycle, in every state.
  always_comb begin
    acc_sum = acc_q + (sum_vld_q ? AW'(sum_q) : '0);
    k_clamp = (bus.k_len > KW'(KMAX)) ? KW'(KMAX) : bus.k_len;
  end

`ifdef SMAC_ACC_SAT_EN
  always_comb begin
    res_sat = (acc_sum > OUT_MAX);
    res_val = res_sat ? '1 : acc_sum[OUT_W-1:0];
  end
`else
  always_comb begin
    res_sat = 1'b0;
    res_val = acc_sum[OUT_W-1:0];
  end
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tile_addr_d = tile_addr_q;
    sum_d       = sum_q;
    sum_vld_d   = 1'b0;
    acc_d       = acc_sum;
    acc_out_d   = acc_out_q;
    sat_d       = sat_q;
    tile_req_d  = tile_req_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tile_addr_d = '0;
          acc_d       = '0;
          k_d         = k_clamp;
          if (k_clamp == '0) begin
            state_d     = S_DONE;
            acc_out_d   = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d    = S_RUN;
            tile_req_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bus.tile_ack) begin
          sum_d     = bus.ba_sum;
          sum_vld_d = 1'b1;
          if (tile_addr_q == k_q - KW'(1)) begin
            state_d    = S_DRAIN;
            tile_req_d = 1'b0;
          end else begin
            tile_addr_d = tile_addr_q + KW'(1);
          end
        end
      end
      S_DRAIN: begin
        state_d     = S_DONE;
        acc_out_d   = res_val;
        sat_d       = res_sat;
        out_valid_d = 1'b1;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          sat_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d     = S_IDLE;
      tile_addr_d = '0;
      sum_d       = '0;
      sum_vld_d   = 1'b0;
      acc_d       = '0;
      acc_out_d   = '0;
      sat_d       = 1'b0;
      tile_req_d  = 1'b0;
      out_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      tile_addr_q <= '0;
      sum_q       <= '0;
      sum_vld_q   <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      sat_q       <= 1'b0;
      tile_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tile_addr_q <= tile_addr_d;
      sum_q       <= sum_d;
      sum_vld_q   <= sum_vld_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      sat_q       <= sat_d;
      tile_req_q  <= tile_req_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    bus.busy      = busy_q;
    bus.tile_req  = tile_req_q;
    bus.tile_addr = tile_addr_q;
    bus.acc_out   = acc_out_q;
    bus.out_valid = out_valid_q;
    bus.sat       = sat_q;
  end
endmodule

// File: tb/tb_bit_adder_seq_ctrl.sv
// Self-checking bench for bit_adder_seq_ctrl: job-level model checked every cycle plus literal pins.
module tb_bit_adder_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   total = 0;
  int   bad = 0;

  bit_adder_seq_ctrl_if #(.KW(5), .SW(16), .OUT_W(16)) bus ();

  bit_adder_seq_ctrl #(.M(16), .Pa(8), .Pw(4), .KMAX(16), .OUT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Job-level model: counts acks and sums, result due two cycles after the final ack.
  int  edge_n = 0;
  int  valid_at = -1;
  int  m_k = 0, m_acks = 0, m_total = 0;
  bit  collecting = 0;
  bit  e_busy = 0, e_req = 0, e_valid = 0, e_sat = 0;
  int  e_addr = 0, e_acc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collecting = 0; valid_at = -1;
      e_busy = 0; e_req = 0; e_valid = 0; e_sat = 0; e_addr = 0; e_acc = 0;
    end else begin
      edge_n++;
      if (clear) begin
        collecting = 0; valid_at = -1;
        e_busy = 0; e_req = 0; e_valid = 0; e_sat = 0; e_addr = 0; e_acc = 0;
      end else if (!e_busy && bus.start) begin
        m_k = (int'(bus.k_len) > 16) ? 16 : int'(bus.k_len);
        e_addr = 0; e_busy = 1; m_total = 0; m_acks = 0;
        if (m_k == 0) begin
          e_valid = 1; e_acc = 0; e_sat = 0;
        end else begin
          collecting = 1; e_req = 1;
        end
      end else if (collecting && bus.tile_ack) begin
        m_total += int'(bus.ba_sum);
        m_acks++;
        if (m_acks == m_k) begin
          collecting = 0; e_req = 0; valid_at = edge_n + 1;
        end else e_addr++;
      end else if (e_valid && bus.out_ready) begin
        e_valid = 0; e_sat = 0; e_busy = 0;
      end
      if (valid_at == edge_n) begin
        valid_at = -1;
        e_valid = 1;
`ifdef SMAC_ACC_SAT_EN
        e_sat = (m_total > 65535);
        e_acc = e_sat ? 65535 : m_total;
`else
        e_sat = 0;
        e_acc = m_total % 65536;
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'(e_busy));
    chk("tile_req", int'(bus.tile_req), int'(e_req));
    chk("tile_addr", int'(bus.tile_addr), e_addr);
    chk("out_valid", int'(bus.out_valid), int'(e_valid));
    chk("acc_out", int'(bus.acc_out), e_acc);
    chk("sat", int'(bus.sat), int'(e_sat));
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic start_job(input int k);
    bus.start = 1'b1; bus.k_len = 5'(k);
    step();
    bus.start = 1'b0;
  endtask

  task automatic ack(input int v);
    bus.tile_ack = 1'b1; bus.ba_sum = 16'(v);
    step();
    bus.tile_ack = 1'b0;
  endtask

  // Returns cycles from the cycle after the last ack until out_valid, bounded.
  task automatic wait_valid(input string nm, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      step(); lat++;
    end
    if (!bus.out_valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    bus.start = 0; bus.k_len = '0; bus.tile_ack = 0; bus.ba_sum = '0; bus.out_ready = 0;
    step(); step();
    chk("reset_acc_out", int'(bus.acc_out), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    step();

    // Async reset in the middle of a job, then a clean job.
    start_job(4); ack(11); ack(22);
    rst_n = 1'b0; #1;
    chk("rst_async_busy", int'(bus.busy), 0);
    chk("rst_async_req", int'(bus.tile_req), 0);
    chk("rst_async_addr", int'(bus.tile_addr), 0);
    step(); rst_n = 1'b1; step();
    start_job(1); ack(42);
    wait_valid("after_rst", lat);
    chk("after_rst_acc", int'(bus.acc_out), 42);
    accept();

    // Back-to-back acks.
    start_job(3); ack(100); ack(200); ack(300);
    wait_valid("k3", lat);
    chk("k3_latency", lat, 2);
    chk("k3_acc", int'(bus.acc_out), 600);
    accept();
    chk("k3_idle", int'(bus.busy), 0);

    // Gapped acks, consumer stalls.
    start_job(2); ack(1000);
    repeat (3) step();
    chk("gap_addr1", int'(bus.tile_addr), 1);
    ack(2000);
    wait_valid("gap", lat);
    for (int i = 0; i < 5; i++) begin
      chk("gap_hold_acc", int'(bus.acc_out), 3000);
      step();
    end
    accept();
    chk("gap_idle", int'(bus.busy), 0);

    // Empty job, then start during RUN ignored.
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    start_job(0);
    chk("k0_valid", int'(bus.out_valid), 1);
    chk("k0_acc", int'(bus.acc_out), 0);
    accept();
    start_job(2);
    bus.start = 1'b1; bus.k_len = 5'd5;
    ack(10); ack(20);
    bus.start = 1'b0;
    wait_valid("restart", lat);
    chk("restart_acc", int'(bus.acc_out), 30);
    accept();

    // Accumulation beyond OUT_W.
    start_job(2); ack(65535); ack(65535);
    wait_valid("big", lat);
`ifdef SMAC_ACC_SAT_EN
    chk("big_acc", int'(bus.acc_out), 65535);
    chk("big_sat", int'(bus.sat), 1);
`else
    chk("big_acc", int'(bus.acc_out), 65534);
    chk("big_sat", int'(bus.sat), 0);
`endif
    accept();
    chk("big_sat_cleared", int'(bus.sat), 0);

    // k_len above KMAX clamps to 16 tiles.
    start_job(20);
    for (int i = 0; i < 16; i++) ack(i + 1);
    wait_valid("clamp", lat);
    chk("clamp_acc", int'(bus.acc_out), 136);
    accept();

    // Clear coincident with an ack.
    start_job(3); ack(500);
    clear = 1'b1; bus.tile_ack = 1'b1; bus.ba_sum = 16'd700;
    step();
    clear = 1'b0; bus.tile_ack = 1'b0;
    chk("clr_busy", int'(bus.busy), 0);
    chk("clr_valid", int'(bus.out_valid), 0);
    repeat (4) step();
    start_job(1); ack(7);
    wait_valid("post_clr", lat);
    chk("post_clr_acc", int'(bus.acc_out), 7);
    accept();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
